// File: rtl/game2048_pkg.sv
// Shared types and helpers for the 2048 move/turn controller.
package game2048_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_MOVE  = 3'd2,
        ST_SPAWN = 3'd3,
        ST_CHECK = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOSE  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int DEF_WIN_EXP = 11;

    // Unsigned add clamped to the largest value representable in w bits (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/game2048_btn_edge.sv
// Rising-edge detect on the four direction buttons, priority up > down > left > right.
module game2048_btn_edge
    import game2048_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] btn_i,        // {right, left, down, up}
    output logic       press_valid_o,
    output dir_e       press_dir_o
);

    logic [3:0] prev_q;
    logic [3:0] press;

    always_ff @(posedge clk_i) begin
        if (reset_i) prev_q <= '0;
        else         prev_q <= btn_i;
    end

    assign press = btn_i & ~prev_q;

    always_comb begin
        press_valid_o = |press;
        press_dir_o   = DIR_UP;
        if      (press[0]) press_dir_o = DIR_UP;
        else if (press[1]) press_dir_o = DIR_DOWN;
        else if (press[2]) press_dir_o = DIR_LEFT;
        else if (press[3]) press_dir_o = DIR_RIGHT;
    end

endmodule

// File: rtl/game2048_move_fsm.sv
// Turn controller: button arbitration, move/spawn handshakes, win/lose evaluation,
// score and move bookkeeping. All outputs decode from registers.
module game2048_move_fsm
    import game2048_pkg::*;
#(
    parameter int SCORE_W        = 16,
    parameter int MOVE_W         = 16,
    parameter int EXP_W          = 4,
    parameter int WIN_EXP        = DEF_WIN_EXP,
    parameter int INIT_TILES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               new_game,
    output logic               move_req,
    output logic [1:0]         move_dir,
    input  logic               move_ack,
    input  logic               move_changed,
    input  logic [SCORE_W-1:0] merge_pts,
    output logic               spawn_req,
    input  logic               spawn_ack,
    input  logic [EXP_W-1:0]   max_exp,
    input  logic               can_move,
    output logic [2:0]         state_o,
    output logic [SCORE_W-1:0] score,
    output logic [MOVE_W-1:0]  moves,
    output logic               busy,
    output logic               win,
    output logic               lose,
    output logic               timeout_err
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = 2;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MOVE_W-1:0]  moves_q, moves_d;
    logic               tmo_q, tmo_d;
    dir_e               dir_q, dir_d;

    logic press_valid;
    dir_e press_dir;
    logic expire;
    logic last_tile;
    logic is_win;

    game2048_btn_edge u_btn (
        .clk_i         (clk),
        .reset_i       (reset),
        .btn_i         ({move_right, move_left, move_down, move_up}),
        .press_valid_o (press_valid),
        .press_dir_o   (press_dir)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            wait_q  <= '0;
            score_q <= '0;
            moves_q <= '0;
            tmo_q   <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            score_q <= score_d;
            moves_q <= moves_d;
            tmo_q   <= tmo_d;
            dir_q   <= dir_d;
        end
    end

    // This is the last waiting cycle: without an ack now, the request is abandoned.
    assign expire    = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign last_tile = (cnt_q == CNT_W'(INIT_TILES - 1));
    assign is_win    = (32'(max_exp) >= 32'(WIN_EXP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        score_d = score_q;
        moves_d = moves_q;
        tmo_d   = tmo_q;
        dir_d   = dir_q;

        case (state_q)
            ST_INIT: begin
                if (spawn_ack) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    wait_d = '0;
                    if (last_tile) state_d = ST_IDLE;
                end else if (expire) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_IDLE: begin
                if (new_game) begin
                    state_d = ST_INIT;
                    score_d = '0;
                    moves_d = '0;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else if (press_valid) begin
                    dir_d   = press_dir;
                    state_d = ST_MOVE;
                    wait_d  = '0;
                end
            end
            ST_MOVE: begin
                if (move_ack) begin
                    score_d = SCORE_W'(sat_add(32'(score_q), 32'(merge_pts), SCORE_W));
                    if (move_changed) begin
                        moves_d = MOVE_W'(sat_add(32'(moves_q), 32'd1, MOVE_W));
                        state_d = ST_SPAWN;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (expire) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_SPAWN: begin
                if (spawn_ack) begin
                    state_d = ST_CHECK;
                end else if (expire) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CHECK: begin
                if      (is_win)    state_d = ST_WIN;
                else if (!can_move) state_d = ST_LOSE;
                else                state_d = ST_IDLE;
            end
            ST_WIN, ST_LOSE: begin
                if (new_game) begin
                    state_d = ST_INIT;
                    score_d = '0;
                    moves_d = '0;
                    cnt_d   = '0;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                wait_d  = '0;
            end
        endcase
    end

    assign state_o     = state_q;
    assign move_req    = (state_q == ST_MOVE);
    assign spawn_req   = (state_q == ST_SPAWN) || (state_q == ST_INIT);
    assign move_dir    = dir_q;
    assign score       = score_q;
    assign moves       = moves_q;
    assign timeout_err = tmo_q;
    assign busy        = (state_q == ST_INIT) || (state_q == ST_MOVE) ||
                         (state_q == ST_SPAWN) || (state_q == ST_CHECK);
    assign win         = (state_q == ST_WIN);
    assign lose        = (state_q == ST_LOSE);

endmodule

// File: tb/tb_game2048_move_fsm.sv
// Bench for game2048_move_fsm: scripted vector table, hand-written corner sequences,
// then randomized traffic against a turn-level reference model.
module tb_game2048_move_fsm;

    localparam int TMO = 20;
    localparam int NT  = 2;
    localparam int WE  = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn = '0;            // {right, left, down, up}
    logic        new_game = 1'b0;
    logic        move_ack = 1'b0;
    logic        move_changed = 1'b0;
    logic [15:0] merge_pts = '0;
    logic        spawn_ack = 1'b0;
    logic [3:0]  max_exp = '0;
    logic        can_move = 1'b1;

    logic        move_req, spawn_req, busy, win, lose, timeout_err;
    logic [1:0]  move_dir;
    logic [2:0]  state_o;
    logic [15:0] score, moves;

    int checks = 0;
    int failures = 0;

    game2048_move_fsm #(
        .SCORE_W(16), .MOVE_W(16), .EXP_W(4), .WIN_EXP(WE),
        .INIT_TILES(NT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .move_up(btn[0]), .move_down(btn[1]), .move_left(btn[2]), .move_right(btn[3]),
        .new_game(new_game),
        .move_req(move_req), .move_dir(move_dir),
        .move_ack(move_ack), .move_changed(move_changed), .merge_pts(merge_pts),
        .spawn_req(spawn_req), .spawn_ack(spawn_ack),
        .max_exp(max_exp), .can_move(can_move),
        .state_o(state_o), .score(score), .moves(moves),
        .busy(busy), .win(win), .lose(lose), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  b;
        logic        ng;
        logic        mack;
        logic        mchg;
        logic [15:0] pts;
        logic        sack;
        logic [3:0]  mexp;
        logic        cm;
        logic [2:0]  e_st;
        logic        e_mreq;
        logic        e_sreq;
        logic [1:0]  e_dir;
        logic [15:0] e_score;
        logic [15:0] e_moves;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic [3:0] b, logic ng, logic mack, logic mchg,
                                logic [15:0] pts, logic sack, logic [3:0] mexp, logic cm,
                                logic [2:0] e_st, logic e_mreq, logic e_sreq, logic [1:0] e_dir,
                                logic [15:0] e_score, logic [15:0] e_moves);
        vec_t v;
        v.rst = rst; v.b = b; v.ng = ng; v.mack = mack; v.mchg = mchg; v.pts = pts;
        v.sack = sack; v.mexp = mexp; v.cm = cm;
        v.e_st = e_st; v.e_mreq = e_mreq; v.e_sreq = e_sreq; v.e_dir = e_dir;
        v.e_score = e_score; v.e_moves = e_moves;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; btn = '0; new_game = 1'b0; move_ack = 1'b0; move_changed = 1'b0;
        merge_pts = '0; spawn_ack = 1'b0; max_exp = '0; can_move = 1'b1;
    endtask

    task automatic do_init();
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0; tick();
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
    endtask

    task automatic press_and_ack(input int d, input logic chg, input logic [15:0] pts);
        btn = 4'(1 << d); tick(); btn = '0;
        move_ack = 1'b1; move_changed = chg; merge_pts = pts; tick();
        move_ack = 1'b0; move_changed = 1'b0; merge_pts = '0;
    endtask

    // Reference model: one game turn step per clock, from the rules of play.
    int       m_st, m_cnt, m_wait, m_score, m_moves, m_dir;
    bit       m_tmo;
    bit [3:0] m_prev;

    function automatic bit waited_out();
        m_wait++;
        return m_wait >= TMO;
    endfunction

    task automatic model_clock();
        bit [3:0] pr;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_wait = 0; m_score = 0; m_moves = 0; m_dir = 0;
            m_tmo = 0; m_prev = '0;
            return;
        end
        pr = btn & ~m_prev;
        m_prev = btn;
        case (m_st)
            0: if (spawn_ack) begin
                   m_cnt++; m_wait = 0;
                   if (m_cnt == NT) m_st = 1;
               end else if (waited_out()) begin m_tmo = 1; m_st = 1; end
            1: if (new_game) begin
                   m_st = 0; m_score = 0; m_moves = 0; m_cnt = 0; m_wait = 0;
               end else if (pr != 0) begin
                   for (int i = 3; i >= 0; i--) if (pr[i]) m_dir = i;
                   m_st = 2; m_wait = 0;
               end
            2: if (move_ack) begin
                   m_score = (m_score + merge_pts > 65535) ? 65535 : m_score + merge_pts;
                   if (move_changed) begin
                       m_moves = (m_moves == 65535) ? 65535 : m_moves + 1;
                       m_st = 3; m_wait = 0;
                   end else m_st = 1;
               end else if (waited_out()) begin m_tmo = 1; m_st = 1; end
            3: if (spawn_ack) m_st = 4;
               else if (waited_out()) begin m_tmo = 1; m_st = 1; end
            4: m_st = (max_exp >= WE) ? 5 : (!can_move ? 6 : 1);
            default: if (new_game) begin
                   m_st = 0; m_score = 0; m_moves = 0; m_cnt = 0; m_wait = 0;
               end
        endcase
    endtask

    initial begin
        logic [42:0] act, exp;
        int hi;

        // reset, two init spawns, prioritized press, changed/unchanged moves, win, new game
        vt.push_back(mk(1, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd0, 0, 1, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd0, 0, 1, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 1, 4'd0, 1, 3'd0, 0, 1, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd0, 0, 1, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 1, 4'd0, 1, 3'd1, 0, 0, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0101, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd2, 1, 0, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd2, 1, 0, 2'd0, 16'd0, 16'd0));
        vt.push_back(mk(0, 4'b0000, 0, 1, 1, 16'd8, 0, 4'd0, 1, 3'd3, 0, 1, 2'd0, 16'd8, 16'd1));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 1, 4'd0, 1, 3'd4, 0, 0, 2'd0, 16'd8, 16'd1));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd3, 1, 3'd1, 0, 0, 2'd0, 16'd8, 16'd1));
        vt.push_back(mk(0, 4'b1000, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd2, 1, 0, 2'd3, 16'd8, 16'd1));
        vt.push_back(mk(0, 4'b1000, 0, 1, 0, 16'd0, 0, 4'd0, 1, 3'd1, 0, 0, 2'd3, 16'd8, 16'd1));
        vt.push_back(mk(0, 4'b0010, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd2, 1, 0, 2'd1, 16'd8, 16'd1));
        vt.push_back(mk(0, 4'b0000, 0, 1, 1, 16'd4, 0, 4'd0, 1, 3'd3, 0, 1, 2'd1, 16'd12, 16'd2));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd3, 0, 1, 2'd1, 16'd12, 16'd2));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 1, 4'd0, 1, 3'd4, 0, 0, 2'd1, 16'd12, 16'd2));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, 16'd0, 0, 4'd11, 0, 3'd5, 0, 0, 2'd1, 16'd12, 16'd2));
        vt.push_back(mk(0, 4'b0001, 0, 0, 0, 16'd0, 0, 4'd0, 1, 3'd5, 0, 0, 2'd1, 16'd12, 16'd2));
        vt.push_back(mk(0, 4'b0000, 1, 0, 0, 16'd0, 0, 4'd0, 1, 3'd0, 0, 1, 2'd1, 16'd0, 16'd0));

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; btn = vt[i].b; new_game = vt[i].ng; move_ack = vt[i].mack;
            move_changed = vt[i].mchg; merge_pts = vt[i].pts; spawn_ack = vt[i].sack;
            max_exp = vt[i].mexp; can_move = vt[i].cm;
            tick();
            chk($sformatf("vec%0d", i),
                64'({state_o, move_req, spawn_req, move_dir, score, moves}),
                64'({vt[i].e_st, vt[i].e_mreq, vt[i].e_sreq, vt[i].e_dir, vt[i].e_score, vt[i].e_moves}));
            if (i == 4)  chk("idle_busy", 64'(busy), 64'd0);
            if (i == 16) chk("win_flags", 64'({win, lose, busy}), 64'b100);
        end
        idle_inputs();

        // held button: one move only
        do_init();
        chk("reinit_idle", 64'(state_o), 64'd1);
        btn = 4'b0100; tick();
        chk("left_move", 64'({move_req, move_dir}), 64'b110);
        move_ack = 1'b1; tick(); move_ack = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (move_req || spawn_req) hi++;
        end
        chk("hold_norepeat", 64'(hi), 64'd0);
        chk("hold_moves", 64'({state_o, moves}), {45'd0, 3'd1, 16'd0});
        btn = '0; tick();

        // move timeout: request held exactly TMO cycles, then abandoned
        btn = 4'b0001; tick(); btn = '0;
        hi = move_req ? 1 : 0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (move_req) hi++;
        end
        chk("tmo_before", 64'(timeout_err), 64'd0);
        tick();
        chk("tmo_len", 64'(hi), 64'(TMO));
        chk("tmo_abort", 64'({state_o, move_req, timeout_err, moves}), {44'd0, 3'd1, 1'b0, 1'b1, 16'd0});

        // ack in the expiry cycle wins
        btn = 4'b0010; tick(); btn = '0;
        for (int i = 0; i < TMO - 1; i++) tick();
        move_ack = 1'b1; move_changed = 1'b1; tick(); move_ack = 1'b0; move_changed = 1'b0;
        chk("ack_at_expiry", 64'({state_o, moves}), {45'd0, 3'd3, 16'd1});
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0; tick();
        chk("tmo_sticky", 64'({state_o, timeout_err}), 64'b0011);

        // score saturation, then reset in the middle of a move with ack present
        reset = 1'b1; tick(); reset = 1'b0;
        chk("tmo_cleared", 64'({timeout_err, state_o}), 64'd0);
        do_init();
        press_and_ack(0, 1'b0, 16'hFFF0);
        chk("score_fff0", 64'(score), 64'hFFF0);
        press_and_ack(1, 1'b0, 16'h0040);
        chk("score_sat", 64'({score, moves}), {32'd0, 16'hFFFF, 16'd0});
        btn = 4'b0100; tick(); btn = '0;
        chk("pre_reset_move", 64'(move_req), 64'd1);
        reset = 1'b1; move_ack = 1'b1; move_changed = 1'b1; merge_pts = 16'd5; tick();
        idle_inputs();
        chk("reset_mid_move", 64'({state_o, move_req, spawn_req, score, moves}),
            {27'd0, 3'd0, 1'b0, 1'b1, 16'd0, 16'd0});

        // randomized turns vs. reference model
        reset = 1'b1; model_clock(); tick(); reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) btn = 4'($urandom_range(0, 15));
            new_game = ($urandom_range(0, 29) == 0);
            move_ack = ($urandom_range(0, 7) == 0);
            move_changed = $urandom_range(0, 1);
            merge_pts = 16'($urandom_range(0, 4096));
            spawn_ack = ($urandom_range(0, 7) == 0);
            max_exp = ($urandom_range(0, 9) == 0) ? 4'd11 : 4'($urandom_range(0, 10));
            can_move = ($urandom_range(0, 6) != 0);
            model_clock();
            tick();
            act = {state_o, move_req, spawn_req, move_dir, busy, win, lose, timeout_err, score, moves};
            exp = {3'(m_st), m_st == 2, (m_st == 0) || (m_st == 3), 2'(m_dir),
                   (m_st == 0) || (m_st == 2) || (m_st == 3) || (m_st == 4),
                   m_st == 5, m_st == 6, m_tmo, 16'(m_score), 16'(m_moves)};
            chk($sformatf("rand%0d", c), 64'(act), 64'(exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
